// File: rtl/matmul_result_drain.sv
// matmul_result_drain: reads result rows of C out of the C BRAM external port
// (base address + stride per row) and streams them on a valid/ready interface.
// A small FIFO with credit-based read issue absorbs the BRAM read latency.
//
// Optional build macro: RESULT_PARITY_EN
//   When defined, adds m_parity: bit i is the XOR of element i of m_data,
//   computed when the row is written into the FIFO and stored with it.
//
// The external port is treated as having its address register in
// bram_addr_c_ext: a read issued on edge N presents bram_rdata_c_ext in time
// for edge N+RD_LATENCY, which is where the FIFO write happens.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | issuing row reads while FIFO credit allows
// DRAIN | all reads issued; waiting for landing and acceptance
// DONE  | one-cycle completion pulse
module matmul_result_drain #(
  parameter int AWIDTH       = 10,
  parameter int DWIDTH       = 8,
  parameter int MAT_MUL_SIZE = 4,
  parameter int MASK_WIDTH   = 4,
  parameter int STRIDE_WIDTH = 8,
  parameter int RD_LATENCY   = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [AWIDTH-1:0]              base_addr,
  input  logic [STRIDE_WIDTH-1:0]        stride,
  input  logic [7:0]                     num_rows,
  output logic                           busy,
  output logic                           done,
  output logic [AWIDTH-1:0]              bram_addr_c_ext,
  output logic [MASK_WIDTH-1:0]          bram_we_c_ext,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata_c_ext,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_rdata_c_ext,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] m_data,
  output logic                           m_last
`ifdef RESULT_PARITY_EN
  ,
  output logic [MAT_MUL_SIZE-1:0]        m_parity
`endif
);

  localparam int WW = MAT_MUL_SIZE * DWIDTH;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [AWIDTH-1:0]       addr_q, addr_d;
  logic [STRIDE_WIDTH-1:0] stride_q, stride_d;
  logic [7:0]              rows_q, rows_d;
  logic [7:0]              issue_cnt_q, issue_cnt_d;
  logic [AWIDTH-1:0]       bram_addr_q, bram_addr_d;

  logic [RD_LATENCY-1:0]   rd_vld_q;
  logic [RD_LATENCY-1:0]   rd_last_q;
  logic [CW-1:0]           inflight;

  logic [WW-1:0]           fifo_data_q [FIFO_DEPTH];
  logic                    fifo_last_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           fifo_cnt_q;

  logic                    issue;
  logic                    last_issue;
  logic                    push;
  logic                    pop;

  assign bram_we_c_ext    = '0;
  assign bram_wdata_c_ext = '0;
  assign bram_addr_c_ext  = bram_addr_q;

  assign busy = (state_q == ISSUE) || (state_q == DRAIN);
  assign done = (state_q == DONE);

  // Count of reads that have been issued but not yet written into the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CW'(rd_vld_q[i]);
    end
  end

  // A read only goes out if its row is guaranteed a FIFO slot on landing.
  assign issue      = (state_q == ISSUE) && (issue_cnt_q < rows_q) &&
                      ((fifo_cnt_q + inflight) < CW'(FIFO_DEPTH));
  assign last_issue = (issue_cnt_q == rows_q - 8'd1);
  assign push       = rd_vld_q[RD_LATENCY-1];
  assign pop        = m_valid && m_ready;

  assign m_valid = (fifo_cnt_q != '0);
  assign m_data  = m_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign m_last  = m_valid ? fifo_last_q[rd_ptr_q] : 1'b0;

  // Next-state, parameter latch and read-issue address generation.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    rows_d      = rows_q;
    issue_cnt_d = issue_cnt_q;
    bram_addr_d = bram_addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          stride_d    = stride;
          rows_d      = num_rows;
          issue_cnt_d = '0;
          state_d     = (num_rows == 8'd0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          bram_addr_d = addr_q;
          addr_d      = addr_q + AWIDTH'(stride_q);
          issue_cnt_d = issue_cnt_q + 8'd1;
          if (last_issue) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave on the edge that accepts the final beat so done follows it directly.
        if ((inflight == '0) &&
            ((fifo_cnt_q == '0) || ((fifo_cnt_q == CW'(1)) && pop))) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and address registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      rows_q      <= '0;
      issue_cnt_q <= '0;
      bram_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      rows_q      <= rows_d;
      issue_cnt_q <= issue_cnt_d;
      bram_addr_q <= bram_addr_d;
    end
  end

  // In-flight read tags; the last-row flag travels with its read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_q  <= '0;
      rd_last_q <= '0;
    end else begin
      rd_vld_q[0]  <= issue;
      rd_last_q[0] <= issue && last_issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_vld_q[i]  <= rd_vld_q[i-1];
        rd_last_q[i] <= rd_last_q[i-1];
      end
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide even when full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // FIFO storage; outputs are gated by m_valid so stale entries never show.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= bram_rdata_c_ext;
      fifo_last_q[wr_ptr_q] <= rd_last_q[RD_LATENCY-1];
    end
  end

`ifdef RESULT_PARITY_EN
  logic [MAT_MUL_SIZE-1:0] fifo_par_q [FIFO_DEPTH];
  logic [MAT_MUL_SIZE-1:0] wr_parity;

  // Per-element even parity of the row being written.
  always_comb begin
    wr_parity = '0;
    for (int i = 0; i < MAT_MUL_SIZE; i++) begin
      wr_parity[i] = ^bram_rdata_c_ext[i*DWIDTH +: DWIDTH];
    end
  end

  // Parity stored alongside its row.
  always_ff @(posedge clk) begin
    if (push) fifo_par_q[wr_ptr_q] <= wr_parity;
  end

  assign m_parity = m_valid ? fifo_par_q[rd_ptr_q] : '0;
`endif

endmodule

// File: tb/tb_matmul_result_drain.sv
// Self-checking bench for matmul_result_drain. The C BRAM is a random-filled
// array read through bram_addr_c_ext (that register is the port's address
// stage). Expected rows come from base + k*stride modulo 1024 looked up in
// that array; last flags, timing and parity come from plain arithmetic.
module tb_matmul_result_drain;

  localparam int AW = 10;
  localparam int WW = 32;
  localparam int FIFO_DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [7:0]    stride;
  logic [7:0]    num_rows;
  logic          busy;
  logic          done;
  logic [AW-1:0] bram_addr_c_ext;
  logic [3:0]    bram_we_c_ext;
  logic [WW-1:0] bram_wdata_c_ext;
  logic [WW-1:0] bram_rdata_c_ext;
  logic          m_valid;
  logic          m_ready;
  logic [WW-1:0] m_data;
  logic          m_last;
`ifdef RESULT_PARITY_EN
  logic [3:0]    m_parity;
  logic [3:0]    got_par [$];
`endif

  logic [WW-1:0] mem [0:1023];

  int vectors;
  int miscompares;

  logic [WW-1:0] got_data [$];
  bit            got_last [$];
  int            got_k    [$];
  logic [AW-1:0] addr_log [$];
  int            done_k;
  int            first_valid_k;
  int            busy_bad;
  int            done_pulses;

  matmul_result_drain dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .base_addr        (base_addr),
    .stride           (stride),
    .num_rows         (num_rows),
    .busy             (busy),
    .done             (done),
    .bram_addr_c_ext  (bram_addr_c_ext),
    .bram_we_c_ext    (bram_we_c_ext),
    .bram_wdata_c_ext (bram_wdata_c_ext),
    .bram_rdata_c_ext (bram_rdata_c_ext),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_data           (m_data),
    .m_last           (m_last)
`ifdef RESULT_PARITY_EN
    ,
    .m_parity         (m_parity)
`endif
  );

  assign bram_rdata_c_ext = mem[bram_addr_c_ext];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW-1:0] row_addr(input logic [AW-1:0] base, input logic [7:0] strd, input int k);
    int a;
    a = (int'(base) + k * int'(strd)) % 1024;
    return AW'(a);
  endfunction

  function automatic logic [3:0] ref_parity(input logic [WW-1:0] w);
    logic [3:0] p;
    for (int e = 0; e < 4; e++) begin
      p[e] = 1'b0;
      for (int b = 0; b < 8; b++) p[e] = p[e] ^ w[e*8+b];
    end
    return p;
  endfunction

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 4 == 0) || (k % 4 == 3);
      default: return 1'b1 & ($urandom_range(0, 1) == 1);
    endcase
  endfunction

  // Runs one drain and records beats, issued addresses and control timing.
  // k counts falling edges after the edge that samples start (k=0 first).
  // Credit and stall-stability rules are checked every cycle.
  task automatic do_drain(input logic [AW-1:0] base, input logic [7:0] strd,
                          input logic [7:0] n, input int mode);
    logic [AW-1:0] last_addr;
    logic          stall_q;
    logic [WW-1:0] hold_data;
    logic          hold_last;
    got_data.delete(); got_last.delete(); got_k.delete(); addr_log.delete();
`ifdef RESULT_PARITY_EN
    got_par.delete();
`endif
    done_k = -1; first_valid_k = -1; busy_bad = 0; done_pulses = 0;
    @(posedge clk); #1;
    base_addr = base; stride = strd; num_rows = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = AW'($urandom); stride = 8'($urandom); num_rows = 8'($urandom);
    last_addr = bram_addr_c_ext;
    stall_q = 1'b0; hold_data = '0; hold_last = 1'b0;
    for (int k = 0; k < 600; k++) begin
      m_ready = ready_for(mode, k);
      @(negedge clk);
      vectors++;
      if (int'(dut.fifo_cnt_q) + int'(dut.inflight) > FIFO_DEPTH) begin
        miscompares++;
        $display("FAIL credit k=%0d: fifo_count+inflight=%0d, limit %0d", k,
                 int'(dut.fifo_cnt_q) + int'(dut.inflight), FIFO_DEPTH);
      end
      if (stall_q) begin
        vectors++;
        if (m_data !== hold_data || m_last !== hold_last) begin
          miscompares++;
          $display("FAIL stall_hold k=%0d: data=%h last=%b, held %h/%b", k, m_data, m_last, hold_data, hold_last);
        end
      end
      stall_q = m_valid && !m_ready; hold_data = m_data; hold_last = m_last;
      if (bram_addr_c_ext !== last_addr) begin
        addr_log.push_back(bram_addr_c_ext);
        last_addr = bram_addr_c_ext;
      end
      if (m_valid && first_valid_k < 0) first_valid_k = k;
      if (m_valid && m_ready) begin
        got_data.push_back(m_data); got_last.push_back(m_last); got_k.push_back(k);
`ifdef RESULT_PARITY_EN
        got_par.push_back(m_parity);
`endif
      end
      if (done) begin
        done_pulses++;
        if (done_k < 0) done_k = k;
        if (busy) busy_bad++;
      end else if (done_k < 0 && !busy) begin
        busy_bad++;
      end
      if (done_k >= 0 && k >= done_k + 2) break;
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    vectors++;
    if (done_k < 0) begin
      miscompares++;
      $display("FAIL drain_timeout: done never seen, required within 600 cycles");
    end
  endtask

  task automatic test_reset();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b need 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b need 0", done); end
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b need 0", m_valid); end
    vectors++; if (m_last !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %b need 0", m_last); end
    vectors++; if (m_data !== '0) begin miscompares++; $display("FAIL reset_data: got %h need 0", m_data); end
    vectors++; if (bram_addr_c_ext !== '0) begin miscompares++; $display("FAIL reset_addr: got %h need 0", bram_addr_c_ext); end
    vectors++; if (bram_we_c_ext !== '0 || bram_wdata_c_ext !== '0) begin
      miscompares++; $display("FAIL reset_wr_tie: we=%h wdata=%h need 0", bram_we_c_ext, bram_wdata_c_ext);
    end
  endtask

  task automatic test_basic();
    do_drain(10'h010, 8'd1, 8'd4, 0);
    vectors++; if (addr_log.size() != 4) begin miscompares++; $display("FAIL basic_addr_count: got %0d need 4", addr_log.size()); end
    for (int i = 0; i < addr_log.size() && i < 4; i++) begin
      vectors++;
      if (addr_log[i] !== row_addr(10'h010, 8'd1, i)) begin
        miscompares++; $display("FAIL basic_addr[%0d]: got %h need %h", i, addr_log[i], row_addr(10'h010, 8'd1, i));
      end
    end
    vectors++; if (got_data.size() != 4) begin miscompares++; $display("FAIL basic_beats: got %0d need 4", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 4; i++) begin
      vectors++;
      if (got_data[i] !== mem[row_addr(10'h010, 8'd1, i)] || got_last[i] !== (i == 3)) begin
        miscompares++; $display("FAIL basic_beat[%0d]: got %h/%b need %h/%b", i, got_data[i], got_last[i],
                                mem[row_addr(10'h010, 8'd1, i)], (i == 3));
      end
      vectors++;
      if (got_k[i] != 2 + i) begin miscompares++; $display("FAIL basic_beat_cycle[%0d]: got %0d need %0d", i, got_k[i], 2 + i); end
    end
    vectors++; if (first_valid_k != 2) begin miscompares++; $display("FAIL basic_first_valid: got %0d need 2", first_valid_k); end
    vectors++; if (done_k != 6) begin miscompares++; $display("FAIL basic_done_cycle: got %0d need 6", done_k); end
    vectors++; if (done_pulses != 1) begin miscompares++; $display("FAIL basic_done_pulses: got %0d need 1", done_pulses); end
    vectors++; if (busy_bad != 0) begin miscompares++; $display("FAIL basic_busy: %0d bad cycles, need 0", busy_bad); end
  endtask

  task automatic test_backpressure();
    do_drain(10'h010, 8'd1, 8'd4, 1);
    vectors++; if (got_data.size() != 4) begin miscompares++; $display("FAIL bp_beats: got %0d need 4", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 4; i++) begin
      vectors++;
      if (got_data[i] !== mem[row_addr(10'h010, 8'd1, i)] || got_last[i] !== (i == 3)) begin
        miscompares++; $display("FAIL bp_beat[%0d]: got %h/%b need %h/%b", i, got_data[i], got_last[i],
                                mem[row_addr(10'h010, 8'd1, i)], (i == 3));
      end
    end
    vectors++;
    if (got_k.size() == 0 || done_k != got_k[got_k.size()-1] + 1) begin
      miscompares++; $display("FAIL bp_done_after_last: got done at %0d, need one after last beat", done_k);
    end
    vectors++; if (done_pulses != 1 || busy_bad != 0) begin
      miscompares++; $display("FAIL bp_ctrl: done_pulses=%0d busy_bad=%0d need 1/0", done_pulses, busy_bad);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [3];
    exp_a[0] = 10'h3FE; exp_a[1] = 10'h002; exp_a[2] = 10'h006;
    do_drain(10'h3FE, 8'd4, 8'd3, 0);
    vectors++; if (addr_log.size() != 3) begin miscompares++; $display("FAIL wrap_addr_count: got %0d need 3", addr_log.size()); end
    for (int i = 0; i < addr_log.size() && i < 3; i++) begin
      vectors++;
      if (addr_log[i] !== exp_a[i]) begin miscompares++; $display("FAIL wrap_addr[%0d]: got %h need %h", i, addr_log[i], exp_a[i]); end
    end
    vectors++; if (got_data.size() != 3) begin miscompares++; $display("FAIL wrap_beats: got %0d need 3", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 3; i++) begin
      vectors++;
      if (got_data[i] !== mem[exp_a[i]] || got_last[i] !== (i == 2)) begin
        miscompares++; $display("FAIL wrap_beat[%0d]: got %h/%b need %h/%b", i, got_data[i], got_last[i], mem[exp_a[i]], (i == 2));
      end
    end
  endtask

  task automatic test_zero_rows();
    do_drain(10'h155, 8'd1, 8'd0, 0);
    vectors++; if (addr_log.size() != 0) begin miscompares++; $display("FAIL zero_addr_moved: got %0d changes need 0", addr_log.size()); end
    vectors++; if (first_valid_k != -1) begin miscompares++; $display("FAIL zero_valid: valid at %0d, need never", first_valid_k); end
    vectors++; if (done_k != 0 || done_pulses != 1) begin
      miscompares++; $display("FAIL zero_done: at %0d pulses %0d, need 0/1", done_k, done_pulses);
    end
    vectors++; if (busy_bad != 0) begin miscompares++; $display("FAIL zero_busy: %0d bad cycles need 0", busy_bad); end
  endtask

  task automatic test_random();
    logic [AW-1:0] b;
    logic [7:0]    s;
    logic [7:0]    n;
    for (int t = 0; t < 8; t++) begin
      b = AW'($urandom); s = 8'($urandom); n = 8'($urandom_range(1, 12));
      do_drain(b, s, n, (t % 3 == 0) ? 0 : 2);
      vectors++;
      if (got_data.size() != int'(n)) begin miscompares++; $display("FAIL rand%0d_beats: got %0d need %0d", t, got_data.size(), n); end
      for (int i = 0; i < got_data.size() && i < int'(n); i++) begin
        vectors++;
        if (got_data[i] !== mem[row_addr(b, s, i)] || got_last[i] !== (i == int'(n) - 1)) begin
          miscompares++; $display("FAIL rand%0d_beat[%0d]: got %h/%b need %h/%b", t, i, got_data[i], got_last[i],
                                  mem[row_addr(b, s, i)], (i == int'(n) - 1));
        end
      end
      vectors++;
      if (got_k.size() == 0 || done_k != got_k[got_k.size()-1] + 1 || done_pulses != 1 || busy_bad != 0) begin
        miscompares++; $display("FAIL rand%0d_ctrl: done_k=%0d pulses=%0d busy_bad=%0d", t, done_k, done_pulses, busy_bad);
      end
    end
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    m_ready = 1'b0; base_addr = 10'h100; stride = 8'd1; num_rows = 8'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (!(m_valid === 1'b1 && int'(dut.fifo_cnt_q) == 2 && int'(dut.inflight) == 1)) begin
      miscompares++; $display("FAIL midrst_setup: valid=%b fifo=%0d inflight=%0d need 1/2/1", m_valid, dut.fifo_cnt_q, dut.inflight);
    end
    #1 reset = 1'b1;
    #1;
    vectors++; if (m_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL midrst_async: valid=%b busy=%b need 0/0", m_valid, busy);
    end
    vectors++; if (m_data !== '0 || m_last !== 1'b0) begin
      miscompares++; $display("FAIL midrst_outputs: data=%h last=%b need 0/0", m_data, m_last);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    m_ready = 1'b1;
    do_drain(10'h200, 8'd3, 8'd2, 0);
    vectors++; if (got_data.size() != 2) begin miscompares++; $display("FAIL midrst_beats: got %0d need 2", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 2; i++) begin
      vectors++;
      if (got_data[i] !== mem[row_addr(10'h200, 8'd3, i)] || got_last[i] !== (i == 1)) begin
        miscompares++; $display("FAIL midrst_beat[%0d]: got %h/%b need %h/%b", i, got_data[i], got_last[i],
                                mem[row_addr(10'h200, 8'd3, i)], (i == 1));
      end
    end
  endtask

`ifdef RESULT_PARITY_EN
  task automatic test_parity();
    mem[10'h120] = 32'h01030700;
    do_drain(10'h120, 8'd1, 8'd4, 1);
    vectors++; if (got_par.size() != 4) begin miscompares++; $display("FAIL par_beats: got %0d need 4", got_par.size()); end
    for (int i = 0; i < got_par.size() && i < 4; i++) begin
      vectors++;
      if (got_par[i] !== ref_parity(mem[row_addr(10'h120, 8'd1, i)])) begin
        miscompares++; $display("FAIL par[%0d]: got %b need %b", i, got_par[i], ref_parity(mem[row_addr(10'h120, 8'd1, i)]));
      end
    end
  endtask
`endif

  initial begin
    vectors = 0; miscompares = 0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    reset = 1'b1; start = 1'b0; base_addr = '0; stride = '0; num_rows = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_rows();
    test_random();
    test_reset_midflight();
`ifdef RESULT_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
